// File: rtl/riscv_trace_buffer.sv
// Retirement-trace capture buffer for the single-cycle RISC-V core.
// Records PC/instruction/rd-write per retirement in a circular buffer and drains it oldest-first.
module riscv_trace_buffer #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cap_valid,
  input  logic [XLEN-1:0] cap_pc,
  input  logic [31:0]     cap_instr,
  input  logic            cap_we,
  input  logic [4:0]      cap_rd,
  input  logic [XLEN-1:0] cap_wdata,
  input  logic            arm,
  input  logic            trig_en,
  input  logic [XLEN-1:0] trig_pc,
  input  logic [CW-1:0]   post_count,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_instr,
  output logic            rd_we,
  output logic [4:0]      rd_rd,
  output logic [XLEN-1:0] rd_wdata,
  output logic [1:0]      state,
  output logic [CW-1:0]   count,
  output logic            triggered,
  output logic            wrapped
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_POST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
  } entry_t;

  state_t        st, st_nxt;
  logic [AW-1:0] wp, wp_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] remaining, remaining_nxt;
  logic          trig_q, trig_nxt;
  logic          wrap_q, wrap_nxt;

  entry_t        mem [DEPTH];
  entry_t        cap_entry;
  entry_t        head_entry;
  logic [AW-1:0] head;
  logic [CW-1:0] post_clamped;
  logic [CW-1:0] cnt_inc;
  logic          capture;
  logic          pop;
  logic          pc_hit;

  assign post_clamped = (post_count > MAX_POST) ? MAX_POST : post_count;
  assign pc_hit       = trig_en && (cap_pc == trig_pc);
  assign capture      = cap_valid && !arm && ((st == S_ARMED) || (st == S_POST));
  // A full buffer overwrites its oldest entry, so the count saturates at DEPTH.
  assign cnt_inc      = (cnt == FULL) ? FULL : cnt + CW'(1);
  assign head         = wp - cnt[AW-1:0];
  assign rd_valid     = (st == S_DONE) && (cnt != '0);
  assign pop          = rd_valid && rd_ready && !arm;

  assign cap_entry = '{pc: cap_pc, instr: cap_instr, we: cap_we, rd: cap_rd, wdata: cap_wdata};

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    st_nxt        = st;
    wp_nxt        = wp;
    cnt_nxt       = cnt;
    remaining_nxt = remaining;
    trig_nxt      = trig_q;
    wrap_nxt      = wrap_q;

    if (arm) begin
      st_nxt        = S_ARMED;
      wp_nxt        = '0;
      cnt_nxt       = '0;
      remaining_nxt = '0;
      trig_nxt      = 1'b0;
      wrap_nxt      = 1'b0;
    end else begin
      if (capture) begin
        wp_nxt  = wp + AW'(1);
        cnt_nxt = cnt_inc;
        if (cnt == FULL) wrap_nxt = 1'b1;
      end

      unique case (st)
        S_IDLE: ;
        S_ARMED: begin
          if (cap_valid) begin
            if (pc_hit) begin
              trig_nxt = 1'b1;
              if (post_clamped == '0) begin
                st_nxt = S_DONE;
              end else begin
                remaining_nxt = post_clamped;
                st_nxt        = S_POST;
              end
            end else if (!trig_en && (cnt_inc == FULL)) begin
              st_nxt = S_DONE;
            end
          end
        end
        S_POST: begin
          if (cap_valid) begin
            remaining_nxt = remaining - CW'(1);
            if (remaining == CW'(1)) st_nxt = S_DONE;
          end
        end
        S_DONE: begin
          // An empty DONE (drained on entry) falls back to IDLE without waiting for a pop.
          if (cnt == '0) begin
            st_nxt = S_IDLE;
          end else if (pop) begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) st_nxt = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= S_IDLE;
      wp        <= '0;
      cnt       <= '0;
      remaining <= '0;
      trig_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      st        <= st_nxt;
      wp        <= wp_nxt;
      cnt       <= cnt_nxt;
      remaining <= remaining_nxt;
      trig_q    <= trig_nxt;
      wrap_q    <= wrap_nxt;
    end
  end

  // NOTE: the entry array is deliberately not reset; count gates every read so stale contents never escape.
  always_ff @(posedge clk) begin
    if (capture) mem[wp] <= cap_entry;
  end

  assign head_entry = rd_valid ? mem[head] : '0;

  assign rd_pc     = head_entry.pc;
  assign rd_instr  = head_entry.instr;
  assign rd_we     = head_entry.we;
  assign rd_rd     = head_entry.rd;
  assign rd_wdata  = head_entry.wdata;
  assign state     = st;
  assign count     = cnt;
  assign triggered = trig_q;
  assign wrapped   = wrap_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Self-checking bench for riscv_trace_buffer: queue-based reference model checked every cycle,
// directed scenarios pinned with literal expectations, then a randomized soak.
module tb_riscv_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            reset;
  logic            cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [31:0]     cap_instr;
  logic            cap_we;
  logic [4:0]      cap_rd;
  logic [XLEN-1:0] cap_wdata;
  logic            arm;
  logic            trig_en;
  logic [XLEN-1:0] trig_pc;
  logic [CW-1:0]   post_count;
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [31:0]     rd_instr;
  logic            rd_we;
  logic [4:0]      rd_rd;
  logic [XLEN-1:0] rd_wdata;
  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic            triggered;
  logic            wrapped;

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .cap_we(cap_we), .cap_rd(cap_rd), .cap_wdata(cap_wdata),
    .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .post_count(post_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_we(rd_we), .rd_rd(rd_rd), .rd_wdata(rd_wdata),
    .state(state), .count(count), .triggered(triggered), .wrapped(wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } ent_t;

  ent_t q[$];
  int   m_state = 0;   // 0 IDLE, 1 ARMED, 2 POST, 3 DONE
  int   m_rem   = 0;
  bit   m_trig  = 0;
  bit   m_wrap  = 0;
  logic [31:0] drained[$];

  function automatic void m_push();
    ent_t e;
    e = '{pc: cap_pc, instr: cap_instr, we: cap_we, rd: cap_rd, wdata: cap_wdata};
    if (q.size() == DEPTH) begin
      void'(q.pop_front());
      m_wrap = 1;
    end
    q.push_back(e);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete(); m_state = 0; m_rem = 0; m_trig = 0; m_wrap = 0;
    end else if (arm) begin
      q.delete(); m_state = 1; m_rem = 0; m_trig = 0; m_wrap = 0;
    end else begin
      case (m_state)
        1: if (cap_valid) begin
          m_push();
          if (trig_en && cap_pc == trig_pc) begin
            int p;
            p = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
            m_trig = 1;
            if (p == 0) m_state = 3;
            else begin m_rem = p; m_state = 2; end
          end else if (!trig_en && q.size() == DEPTH) begin
            m_state = 3;
          end
        end
        2: if (cap_valid) begin
          m_push();
          m_rem--;
          if (m_rem == 0) m_state = 3;
        end
        3: begin
          if (q.size() == 0) m_state = 0;
          else if (rd_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) m_state = 0;
          end
        end
        default: ;
      endcase
    end
  end

  // Compare process: outputs are stable mid-cycle, away from the capturing edge.
  always @(negedge clk) begin
    if (reset) begin
      check("state", 64'(state), 64'(m_state));
      check("count", 64'(count), 64'(q.size()));
      check("rd_valid", 64'(rd_valid), 64'(m_state == 3 && q.size() != 0));
      check("triggered", 64'(triggered), 64'(m_trig));
      check("wrapped", 64'(wrapped), 64'(m_wrap));
      if (rd_valid && q.size() != 0) begin
        check("rd_pc", 64'(rd_pc), 64'(q[0].pc));
        check("rd_instr", 64'(rd_instr), 64'(q[0].instr));
        check("rd_we", 64'(rd_we), 64'(q[0].we));
        check("rd_rd", 64'(rd_rd), 64'(q[0].rd));
        check("rd_wdata", 64'(rd_wdata), 64'(q[0].wdata));
      end
      if (rd_valid && rd_ready && !arm) drained.push_back(rd_pc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cap_full(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                          input logic [31:0] wdata);
    cap_valid = 1'b1;
    cap_pc    = pc;
    cap_instr = $urandom;
    cap_we    = we;
    cap_rd    = rd;
    cap_wdata = wdata;
    step();
    cap_valid = 1'b0;
  endtask

  task automatic cap(input logic [31:0] pc);
    cap_full(pc, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
  endtask

  task automatic do_arm(input logic te, input logic [31:0] tpc, input int pcnt);
    arm        = 1'b1;
    trig_en    = te;
    trig_pc    = tpc;
    post_count = CW'(pcnt);
    rd_ready   = 1'b0;
    step();
    arm = 1'b0;
  endtask

  task automatic drain(input string name);
    cap_valid = 1'b0;
    rd_ready  = 1'b1;
    for (int i = 0; i < 60 && state != 2'b00; i++) step();
    check({name, "_idle"}, 64'(state), 64'd0);
    rd_ready = 1'b0;
  endtask

  task automatic check_drained(input string name, input logic [31:0] first, input int n);
    check({name, "_n"}, 64'(drained.size()), 64'(n));
    for (int i = 0; i < n && i < drained.size(); i++)
      check({name, "_pc"}, 64'(drained[i]), 64'(first + 32'(4 * i)));
  endtask

  // ---------------- scenarios ----------------
  initial begin
    reset = 1'b0; cap_valid = 1'b0; cap_pc = '0; cap_instr = '0; cap_we = 1'b0;
    cap_rd = '0; cap_wdata = '0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0;
    post_count = '0; rd_ready = 1'b0;

    #12;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_triggered", 64'(triggered), 64'd0);
    check("rst_wrapped", 64'(wrapped), 64'd0);
    check("rst_rd_pc", 64'(rd_pc), 64'd0);
    check("rst_rd_instr", 64'(rd_instr), 64'd0);
    check("rst_rd_wdata", 64'(rd_wdata), 64'd0);
    @(negedge clk); #1 reset = 1'b1;
    step();

    // Fill mode: 10 captures, only the first 8 are kept.
    do_arm(1'b0, 32'h0, 0);
    for (int i = 0; i < 10; i++) cap(32'(4 * i));
    check("fill_state_done", 64'(state), 64'd3);
    check("fill_count", 64'(count), 64'd8);
    drained.delete();
    drain("fill");
    check_drained("fill", 32'h00, 8);
    check("fill_wrapped", 64'(wrapped), 64'd0);

    // Trigger at 0x40 with two post entries; the buffer wraps.
    do_arm(1'b1, 32'h40, 2);
    for (int i = 0; i < 20; i++) cap(32'(4 * i));
    drained.delete();
    drain("trig");
    check_drained("trig", 32'h2C, 8);
    check("trig_triggered", 64'(triggered), 64'd1);
    check("trig_wrapped", 64'(wrapped), 64'd1);

    // post_count above DEPTH-1 is clamped to 7.
    do_arm(1'b1, 32'h10, 9);
    for (int i = 0; i < 16; i++) cap(32'(4 * i));
    drained.delete();
    drain("clamp");
    check_drained("clamp", 32'h10, 8);

    // Backpressure on the drain port.
    do_arm(1'b0, 32'h0, 0);
    cap_full(32'h100, 1'b1, 5'd1, 32'h5);
    for (int i = 1; i < 8; i++) cap(32'h100 + 32'(4 * i));
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_stall_pc", 64'(rd_pc), 64'h100);
      check("bp_stall_we", 64'(rd_we), 64'd1);
      check("bp_stall_rd", 64'(rd_rd), 64'd1);
      check("bp_stall_wdata", 64'(rd_wdata), 64'h5);
      check("bp_stall_count", 64'(count), 64'd8);
    end
    begin
      int exp_cnt;
      exp_cnt = 8;
      for (int i = 0; i < 10; i++) begin
        rd_ready = 1'(i % 2);
        step();
        if (rd_ready && exp_cnt > 0) exp_cnt--;
        check("bp_toggle_count", 64'(count), 64'(exp_cnt));
      end
    end
    drain("bp");

    // Reset asserted in the middle of POST.
    do_arm(1'b1, 32'h8, 5);
    for (int i = 0; i < 4; i++) cap(32'(4 * i));
    check("post_state", 64'(state), 64'd2);
    #1 reset = 1'b0;
    #1;
    check("midrst_state", 64'(state), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_rd_valid", 64'(rd_valid), 64'd0);
    @(negedge clk); #1 reset = 1'b1;
    step();
    for (int i = 0; i < 3; i++) cap(32'h300 + 32'(4 * i));
    check("postrst_count", 64'(count), 64'd0);
    check("postrst_state", 64'(state), 64'd0);

    // arm colliding with a pop and a capture in DONE.
    do_arm(1'b0, 32'h0, 0);
    for (int i = 0; i < 8; i++) cap(32'h200 + 32'(4 * i));
    rd_ready = 1'b1;
    step();
    check("coll_pre_count", 64'(count), 64'd7);
    arm = 1'b1; cap_valid = 1'b1; cap_pc = 32'h999;
    step();
    arm = 1'b0; rd_ready = 1'b0;
    check("coll_state", 64'(state), 64'd1);
    check("coll_count", 64'(count), 64'd0);
    cap(32'h123);
    check("coll_next_count", 64'(count), 64'd1);
    for (int i = 0; i < 7; i++) cap(32'h400 + 32'(4 * i));
    drained.delete();
    drain("coll");
    check("coll_first", drained.size() > 0 ? 64'(drained[0]) : 64'hdead, 64'h123);

    // Randomized soak against the model.
    for (int c = 0; c < 3000; c++) begin
      arm = (c == 0) || ($urandom_range(0, 39) == 0);
      if (arm) begin
        trig_en    = 1'($urandom_range(0, 1));
        trig_pc    = 32'(16 * $urandom_range(1, 3));
        post_count = CW'($urandom_range(0, 15));
      end
      cap_valid = ($urandom_range(0, 9) < 7);
      cap_pc    = 32'(4 * $urandom_range(0, 15));
      cap_instr = $urandom;
      cap_we    = 1'($urandom_range(0, 1));
      cap_rd    = 5'($urandom_range(0, 31));
      cap_wdata = $urandom;
      rd_ready  = 1'($urandom_range(0, 1));
      step();
    end
    arm = 1'b0; cap_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

- Parametrised, synthesizable retirement-trace capture unit for the single-cycle RISC-V core. Records the retired PC, instruction word and register-file write for each instruction in a circular buffer.
- Supports PC-match triggering with a programmable post-trigger window, or a plain fill mode.
- Sits beside `top`, fed from the datapath's PC, instruction and register-write signals.
- Drains captured entries oldest-first over a valid/ready port, so a bench or debug bridge can dump the run without hierarchical peeking.

## Interface
- `XLEN`, 32: PC and register data width.
- `DEPTH`, 8: buffer entries; power of two, at least 4. `CW = $clog2(DEPTH)+1`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (`reset=0` resets).
- `cap_valid`  in  1  one instruction retires this cycle.
- `cap_pc`  in  XLEN  PC of the retiring instruction.
- `cap_instr`  in  32  instruction word.
- `cap_we`  in  1  register-file write enable.
- `cap_rd`  in  5  destination register.
- `cap_wdata`  in  XLEN  write data.
- `arm`  in  1  single-cycle pulse; clears the buffer and starts capture.
- `trig_en`  in  1  1 = PC-match trigger mode, 0 = fill mode; sampled every cycle.
- `trig_pc`  in  XLEN  trigger PC.
- `post_count`  in  CW  entries captured after the trigger entry; sampled at trigger; clamped to DEPTH-1.
- `rd_valid`  out  1  head entry is available.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_pc`, `rd_instr`, `rd_we`, `rd_rd`, `rd_wdata`  out  XLEN/32/1/5/XLEN  head entry fields.
- `state`  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE.
- `count`  out  CW  valid entries held.
- `triggered`  out  1  trigger has fired since the last arm.
- `wrapped`  out  1  an entry was overwritten since the last arm.

## Operation
- Storage: DEPTH-entry register array, write pointer `wp` modulo DEPTH. The head (oldest) entry index is `(wp - count) mod DEPTH`.
- A capture writes the cap_* fields at `wp`, then increments `wp`.
  - If `count < DEPTH`, `count` increments.
  - Otherwise `count` stays at DEPTH, the oldest entry is overwritten and `wrapped` is set.
- IDLE:
  - cap_valid is ignored.
  - `arm` moves to ARMED.
- ARMED: every cap_valid is captured.
  - Trigger mode: if `trig_en && cap_pc == trig_pc`, the matching entry is captured and `triggered` is set. Then:
    - if the clamped post_count is 0, go to DONE;
    - otherwise load `remaining` = clamped post_count and go to POST.
  - Fill mode (`trig_en=0`): when the capture makes `count == DEPTH`, go to DONE. No wrap occurs in fill mode.
- POST:
  - Every cap_valid is captured and decrements `remaining`.
  - The capture that makes `remaining` 0 moves to DONE.
  - PC matches are ignored.
- DONE:
  - cap_valid is ignored.
  - `rd_valid = (count != 0)`; rd_* show the head entry.
  - A handshake (`rd_valid && rd_ready`) decrements `count`.
  - When `count` reaches 0 after a pop, go to IDLE. `triggered` and `wrapped` hold until the next arm or reset.
- `arm` in any state (abort/restart):
  - clears `count`, `wp`, `remaining`, `triggered` and `wrapped`;
  - goes to ARMED;
  - takes priority over any capture or pop in the same cycle. That cycle's cap_valid is not recorded and no pop occurs.
- In DONE with `count == 0` (the buffer was drained empty on entry), go to IDLE on the next cycle.

## Timing
- Reset values (asynchronous, while reset=0):
  - state = IDLE; `wp`, `count`, `remaining` = 0;
  - `rd_valid` = 0, `triggered` = 0, `wrapped` = 0;
  - rd_* fields = 0.
  - Array contents are don't-care.
- Reset mid-capture or mid-drain aborts immediately; no pending entry is retained.
- Capture latency: an entry presented at edge N is counted in `count` after edge N. A capture that completes the window sets state=DONE at edge N, so `rd_valid` goes high in the cycle after edge N.
- Read path: rd_* are combinational from the array at the head index. They are stable while `rd_valid && !rd_ready`. The next entry appears in the cycle after each accepted pop.
- Throughput: one capture per cycle, one pop per cycle.

## Test plan
- DEPTH=8, fill mode, arm, then 10 captures with PC 0x00,0x04,…,0x24 (one per cycle): DONE after the 8th capture; drain yields PCs 0x00..0x1C in order; `wrapped=0`; state returns to IDLE.
- Trigger mode, trig_pc=0x40, post_count=2, PCs 0x00..0x4C step 4:
  - capture stops after PC 0x48;
  - drain yields 8 entries, 0x2C..0x48;
  - `triggered=1`, `wrapped=1`.
- post_count=9 (clamped to 7), trig_pc=0x10, PCs from 0x00: first drained entry is PC 0x10, followed by 7 more entries, 0x14..0x2C.
- Backpressure: in DONE, hold `rd_ready=0` for 3 cycles, then toggle it every cycle. Required: rd_* stable while stalled; `count` decrements only on handshake cycles; rd_we/rd_rd/rd_wdata match their captures (e.g. x1=0x5).
- Assert reset=0 in the middle of POST: state=IDLE, `count=0` and `rd_valid=0` immediately (before the next edge); after release, cap_valid is ignored until `arm`.
- `arm` in the same cycle as a DONE pop and a cap_valid: state=ARMED, `count=0`, no pop, nothing captured; the next cycle's cap_valid is stored as entry 0.
